// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
//
// Purpose: groups the two streaming handshakes of the ALU operand sequencer.
//   The operand stream carries operand beats into the sequencer. The result
//   stream carries the captured ALU result and flags out of it.
//
// Signals:
//   in_valid / in_ready   operand beat handshake
//   in_op      [2:0]      opcode (used on the first beat of an operation)
//   in_data    [WIDTH-1:0] operand data (A on first beat, B on second)
//   in_chain              chain request (only when ALU_SEQ_CHAIN_EN is defined)
//   res_valid / res_ready result handshake
//   res_data   [WIDTH-1:0] captured result
//   res_cout / res_sign / res_ovf  captured flags
//
// Modports:
//   master  producer of operands and consumer of results (the environment)
//   slave   the sequencer itself
//
// Optional feature macro: ALU_SEQ_CHAIN_EN (adds in_chain).
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if #(
  parameter int WIDTH = 12
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_data;
`ifdef ALU_SEQ_CHAIN_EN
  logic             in_chain;
`endif
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_cout;
  logic             res_sign;
  logic             res_ovf;

  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  res_data,
    input  res_cout,
    input  res_sign,
    input  res_ovf
`ifdef ALU_SEQ_CHAIN_EN
    , output in_chain
`endif
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  res_ready,
    output in_ready,
    output res_valid,
    output res_data,
    output res_cout,
    output res_sign,
    output res_ovf
`ifdef ALU_SEQ_CHAIN_EN
    , input in_chain
`endif
  );

endinterface

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//
// Purpose: front-end for the 12-bit ALU. Operand beats arrive on a
//   valid/ready stream and are assembled into registered operand A, operand B
//   and opcode that drive the ALU. One cycle after the last beat the ALU
//   result and flags are captured and offered on a valid/ready result port.
//   A sticky overflow flag and a completed-operation counter are kept for the
//   surrounding datapath.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         alu_operand_sequencer_if.slave (operand and result streams)
//   alu_a/b     registered operands to the ALU
//   alu_op      registered opcode to the ALU
//   alu_out     ALU result (combinational from alu_a/alu_b/alu_op)
//   alu_cout/alu_sign/alu_ovf  ALU flags
//   sticky_clr  clears ovf_sticky (an overflow capture on the same edge wins)
//   ovf_sticky  set by any captured overflow
//   op_count    number of results handed off, wraps modulo 2^CNT_W
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   When defined, bus.in_chain is sampled on the first beat. With in_chain=1
//   and at least one completed operation, the previous result becomes
//   operand A; binary ops then take in_data as B in a single beat and unary
//   ops ignore in_data.
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int         WIDTH      = 12,
  parameter logic [7:0] UNARY_MASK = 8'b0010_0011,
  parameter int         CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_operand_sequencer_if.slave bus,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_cout,
  input  logic                  alu_sign,
  input  logic                  alu_ovf,
  input  logic                  sticky_clr,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [2:0]       op_reg, op_next;

  logic [WIDTH-1:0] res_data_reg;
  logic             res_cout_reg;
  logic             res_sign_reg;
  logic             res_ovf_reg;
  logic             res_valid_reg;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic accept;
  logic capture;
  logic handoff;
  logic is_unary;
  logic chain_ok;

  // Operand stream is open only while collecting beats.
  assign bus.in_ready = (state_reg == IDLE) || (state_reg == GET_B);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_unary     = UNARY_MASK[bus.in_op];

`ifdef ALU_SEQ_CHAIN_EN
  // Chaining needs a real previous result; before the first handoff the
  // request silently degrades to a normal operation.
  assign chain_ok = bus.in_chain && (cnt_reg != '0);
`else
  assign chain_ok = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and operand selection
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    capture    = 1'b0;
    handoff    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next = bus.in_op;
          if (chain_ok) begin
            a_next     = res_data_reg;
            b_next     = is_unary ? '0 : bus.in_data;
            state_next = EXEC;
          end else begin
            a_next = bus.in_data;
            if (is_unary) begin
              b_next     = '0;
              state_next = EXEC;
            end else begin
              state_next = GET_B;
            end
          end
        end
      end

      GET_B: begin
        // The opcode was fixed on the first beat; in_op is not looked at here.
        if (accept) begin
          b_next     = bus.in_data;
          state_next = EXEC;
        end
      end

      EXEC: begin
        // Operands have been stable at the ALU for a full cycle.
        capture    = 1'b1;
        state_next = HOLD;
      end

      HOLD: begin
        if (res_valid_reg && bus.res_ready) begin
          handoff    = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand registers: only accepted beats move them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else begin
      a_reg  <= a_next;
      b_reg  <= b_next;
      op_reg <= op_next;
    end
  end

  // -------------------------------------------------------------------------
  // Result capture, handoff and completed-operation counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_reg  <= '0;
      res_cout_reg  <= 1'b0;
      res_sign_reg  <= 1'b0;
      res_ovf_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (capture) begin
        res_data_reg  <= alu_out;
        res_cout_reg  <= alu_cout;
        res_sign_reg  <= alu_sign;
        res_ovf_reg   <= alu_ovf;
        res_valid_reg <= 1'b1;
      end else if (handoff) begin
        res_valid_reg <= 1'b0;
        cnt_reg       <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overflow: a capture with overflow takes precedence over a clear
  // arriving on the same edge, so no overflow event is ever lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (capture && alu_ovf) begin
      sticky_reg <= 1'b1;
    end else if (sticky_clr) begin
      sticky_reg <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign alu_a         = a_reg;
  assign alu_b         = b_reg;
  assign alu_op        = op_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_cout  = res_cout_reg;
  assign bus.res_sign  = res_sign_reg;
  assign bus.res_ovf   = res_ovf_reg;
  assign ovf_sticky    = sticky_reg;
  assign op_count      = cnt_reg;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream front-end for the 12-bit ALU. It accepts operand beats over a valid/ready stream and assembles operand A, operand B and the opcode into stable registers that drive the ALU inputs. One cycle later it captures the ALU result and flags, then presents them on a valid/ready result port. It also keeps a sticky overflow flag and a completed-operation counter for the surrounding datapath.

Parameters:
WIDTH, 12, operand/result width; must match the ALU.
UNARY_MASK, 8'b0010_0011, bit n set means opcode n is single-operand (ops 0, 1, 5); all other opcodes take two beats.
CNT_W, 8, width of op_count.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  sequencer can accept a beat
in_op  input  3  opcode; sampled on the first beat only
in_data  input  WIDTH  operand data (A on first beat, B on second)
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
alu_cout  input  1  ALU carry out
alu_sign  input  1  ALU sign flag
alu_ovf  input  1  ALU overflow flag
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_cout  output  1  captured carry
res_sign  output  1  captured sign
res_ovf  output  1  captured overflow
sticky_clr  input  1  clears ovf_sticky
ovf_sticky  output  1  set by any captured overflow
op_count  output  CNT_W  number of results handed off

Behaviour:
- Reset (async, rst_n=0): state IDLE. alu_a, alu_b, alu_op, res_* and op_count are 0. res_valid=0, ovf_sticky=0. in_ready reflects IDLE, so it is 1 while in reset.
- States: IDLE, GET_B, EXEC, HOLD. in_ready=1 only in IDLE and GET_B.
- IDLE, beat accepted (in_valid&in_ready):
  - alu_op<=in_op; alu_a<=in_data.
  - If UNARY_MASK[in_op]: alu_b<=0, go to EXEC. Otherwise go to GET_B.
- GET_B, beat accepted: alu_b<=in_data and go to EXEC. in_op is ignored on this beat.
- EXEC (exactly one cycle): at the closing edge, res_data/res_cout/res_sign/res_ovf <= alu_out/alu_cout/alu_sign/alu_ovf. res_valid<=1, then go to HOLD.
- Latency: res_valid rises on the edge one clock after the edge that accepted the last operand beat.
- HOLD: res_* are stable. On res_valid&res_ready: res_valid<=0, op_count<=op_count+1 (wraps modulo 2^CNT_W), go to IDLE. No new beat is accepted in the handoff cycle.
- alu_a/alu_b/alu_op change only on accepted beats. In HOLD and IDLE they keep their last values.
- ovf_sticky:
  - Set on the EXEC edge when alu_ovf=1.
  - Cleared by sticky_clr=1 on any other edge.
  - If set and clear occur on the same edge, set wins.
- in_valid while in_ready=0 (EXEC/HOLD) is not consumed; the producer holds the beat.
- rst_n deasserted mid-operation (GET_B/EXEC/HOLD): any partial operand is discarded and all outputs return to reset values immediately.

Optional Feature:
ALU_SEQ_CHAIN_EN: adds input port in_chain (1 bit), sampled on the IDLE beat.
- in_chain=1 and op_count!=0: alu_a<=res_data (previous result).
  - Binary op: alu_b<=in_data, go straight to EXEC (single beat).
  - Unary op: in_data is ignored.
- in_chain=1 and op_count==0: treated as in_chain=0.
- Macro undefined: port absent, and every op follows the normal one- or two-beat protocol.

Test Plan:
Bench stub ALU: alu_out=alu_a+alu_b (mod 2^12); cout=carry; sign=msb; ovf=signed overflow.
1. Reset, then a binary op. rst_n=0 -> all outputs 0, in_ready=1. Then op=6, beats 0x60F, 0x061 -> res_data=0x670, cout=0, ovf=0, res_valid 1 clk after 2nd beat.
2. Unary op with overflow. op=0, single beat 0xEF1 -> alu_b=0, res_data=0xEF1, sign=1. Then op=6, beats 0x69F, 0x769 -> res_data=0xE08, ovf=1, ovf_sticky=1.
3. Backpressure. res_ready=0 for 5 clks -> res_* stable, in_ready=0, extra in_valid not consumed. res_ready=1 -> op_count increments, state IDLE.
4. Sticky precedence. sticky_clr=1 on the same edge as an overflowing capture -> ovf_sticky stays 1. sticky_clr=1 next edge -> ovf_sticky=0.
5. Mid-op reset. rst_n pulsed low in GET_B -> state IDLE. Then a unary op 0x001 -> res_data=0x001; op_count wraps 255->0 after 256 handoffs.
6. Chaining (ALU_SEQ_CHAIN_EN). After result 0x670, op=6, in_chain=1, data 0x010 -> single beat, res_data=0x680.
